pc_fetch_controller: RTL

Sequencer for the program counter in the pipelined core's fetch stage. Owns the PC register and chooses next PC among sequential (+4), redirect (branch/jump resolved in EX), trap vector, or hold (stall/halt). Drives instruction-memory request handshake and tells IF/ID when a fetched PC is valid. Sits between hazard unit, EX-stage branch logic, instruction memory and IF/ID pipeline register.

---
 rtl/pc_fetch_controller.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pc_fetch_controller.sv
// ---------------------------------------------------------------------------
// pc_fetch_controller
//
// Sequences the program counter for the fetch stage of the pipelined core.
// It owns the PC register and picks the next PC from one of four sources:
//   - sequential advance (+4)
//   - a redirect resolved in EX
//   - the trap vector, taken when a redirect target is misaligned
//   - hold, for stall, halt or a memory that is not ready
// It also drives the instruction-memory request, tells IF/ID when the
// instruction at pc_o has been accepted, and counts stalled fetch cycles.
//
// Parameters:
//   RESET_VECTOR  PC loaded on reset
//   TRAP_VECTOR   PC loaded when a misaligned redirect is trapped
//   STALL_CNT_W   width of the saturating stall-cycle counter
//
// Ports:
//   clk               clock; all state updates on the rising edge
//   rst               synchronous active-high reset, overrides all inputs
//   stall_i           hazard unit asks for the PC to be held
//   redirect_valid_i  EX stage redirect request
//   redirect_pc_i     redirect target
//   halt_i            ebreak/halt request from decode
//   imem_req_o        instruction-memory request
//   imem_addr_o       fetch address (always equal to pc_o)
//   imem_ready_i      memory returns the instruction this cycle
//   pc_o              current PC
//   pc_valid_o        instruction at pc_o accepted into IF/ID this cycle
//   flush_o           one-cycle pulse: flush IF/ID and ID/EX
//   misalign_o        one-cycle pulse: misaligned redirect was trapped
//   halted_o          controller is halted
//   stall_cnt_o       stalled-cycle count, saturating at all-ones
// ---------------------------------------------------------------------------
module pc_fetch_controller #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   redirect_valid_i,
  input  logic [31:0]            redirect_pc_i,
  input  logic                   halt_i,
  output logic                   imem_req_o,
  output logic [31:0]            imem_addr_o,
  input  logic                   imem_ready_i,
  output logic [31:0]            pc_o,
  output logic                   pc_valid_o,
  output logic                   flush_o,
  output logic                   misalign_o,
  output logic                   halted_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2,
    S_TRAP  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic                   flush_q, flush_d;
  logic                   misalign_q, misalign_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // State register; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_VECTOR;
      flush_q     <= 1'b0;
      misalign_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      flush_q     <= flush_d;
      misalign_q  <= misalign_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state and next-PC selection. Redirects are honoured only while the
  // front-end is fetching or halted; BOOT and TRAP are single fixed cycles.
  // In FETCH the priority is redirect > halt > stall > ready/hold. The
  // flush/misalign pulses are produced as next-state values so they appear
  // registered, exactly one cycle after the redirect is accepted.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flush_d     = 1'b0;
    misalign_d  = 1'b0;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end

      S_TRAP: begin
        state_d = S_FETCH;
      end

      S_FETCH, S_HALT: begin
        if (redirect_valid_i) begin
          // Any unfinished memory request at the old PC is simply dropped.
          flush_d = 1'b1;
          if (redirect_pc_i[1:0] != 2'b00) begin
            pc_d       = TRAP_VECTOR;
            misalign_d = 1'b1;
            state_d    = S_TRAP;
          end else begin
            pc_d    = redirect_pc_i;
            state_d = S_FETCH;
          end
        end else if (state_q == S_FETCH) begin
          if (halt_i) begin
            state_d = S_HALT;
          end else if (stall_i) begin
            if (stall_cnt_q != {STALL_CNT_W{1'b1}}) begin
              stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
            end
          end else if (imem_ready_i) begin
            // Wraps modulo 2^32 with no indication.
            pc_d = pc_q + 32'd4;
          end
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  assign imem_req_o  = (state_q == S_FETCH);
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign halted_o    = (state_q == S_HALT);
  assign flush_o     = flush_q;
  assign misalign_o  = misalign_q;
  assign stall_cnt_o = stall_cnt_q;

  // Acceptance is combinational so IF/ID can capture in the same cycle that
  // the memory answers; anything that changes the PC path vetoes it.
  assign pc_valid_o = (state_q == S_FETCH) && imem_ready_i && !stall_i &&
                      !redirect_valid_i && !halt_i;

endmodule
